// File: rtl/prog_counter_pkg.sv
// rtl/prog_counter_pkg.sv - shared mode/state encodings and direction constants for prog_counter
package prog_counter_pkg;

    typedef enum logic [1:0] {
        MODE_FREE    = 2'b00,
        MODE_MOD     = 2'b01,
        MODE_ONESHOT = 2'b10,
        MODE_HOLD    = 2'b11
    } mode_e;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } state_e;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/prog_counter_prescaler.sv
// rtl/prog_counter_prescaler.sv - enable-gated prescaler, one tick every prescale+1 advancing cycles
module prog_counter_prescaler
    import prog_counter_pkg::*;
#(
    parameter int PRE_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             advance,
    input  logic             restart,
    input  logic [PRE_W-1:0] prescale,
    output logic             tick
);

    logic [PRE_W-1:0] r_pre_cnt;
    logic             w_match;

    assign w_match = (r_pre_cnt == prescale);
    assign tick    = advance && w_match;

    // A prescale lowered below r_pre_cnt lets the count run on and wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre_cnt <= '0;
        end else if (restart) begin
            r_pre_cnt <= '0;
        end else if (advance) begin
            r_pre_cnt <= w_match ? '0 : r_pre_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/prog_counter.sv
// rtl/prog_counter.sv - prescaled FREE/MOD/ONESHOT/HOLD up/down counter with terminal-count pulse
// Optional capture port set enabled by defining PROG_COUNTER_CAPTURE_EN.
module prog_counter
    import prog_counter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int PRE_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             dir,
    input  logic             clear,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_value,
    input  logic [WIDTH-1:0] limit,
    input  logic [PRE_W-1:0] prescale,
`ifdef PROG_COUNTER_CAPTURE_EN
    input  logic             capture,
    output logic [WIDTH-1:0] cap_value,
    output logic             cap_valid,
`endif
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             done,
    output logic             running
);

    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic             r_done;
    logic [0:0]       r_state;

    logic             w_advance;
    logic             w_restart;
    logic             w_tick;
    logic             w_up;
    logic [WIDTH-1:0] w_count_nxt;
    logic             w_tc_nxt;
    logic [0:0]       w_state_nxt;

    assign w_advance = (r_state == ST_RUN) && en && (mode != MODE_HOLD);
    assign w_restart = clear || load_valid;
    assign w_up      = (dir == DIR_UP);

    prog_counter_prescaler #(
        .PRE_W    (PRE_W)
    ) u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .advance  (w_advance),
        .restart  (w_restart),
        .prescale (prescale),
        .tick     (w_tick)
    );

    // Strobes outrank the tick; all wrap/terminal decisions look at the pre-step count.
    always_comb begin
        w_count_nxt = r_count;
        w_tc_nxt    = 1'b0;
        w_state_nxt = r_state;
        if (clear) begin
            w_count_nxt = '0;
            w_state_nxt = ST_RUN;
        end else if (load_valid) begin
            w_count_nxt = load_value;
            w_state_nxt = ST_RUN;
        end else if (r_state == ST_DONE) begin
            if (mode != MODE_ONESHOT) begin
                w_state_nxt = ST_RUN;
            end
        end else if (w_tick) begin
            case (mode)
                MODE_FREE: begin
                    if (w_up) begin
                        w_count_nxt = r_count + CNT_ONE;
                        w_tc_nxt    = (r_count == CNT_MAX);
                    end else begin
                        w_count_nxt = r_count - CNT_ONE;
                        w_tc_nxt    = (r_count == '0);
                    end
                end
                MODE_MOD: begin
                    if (w_up) begin
                        if (r_count >= limit) begin
                            w_count_nxt = '0;
                            w_tc_nxt    = 1'b1;
                        end else begin
                            w_count_nxt = r_count + CNT_ONE;
                        end
                    end else begin
                        if (r_count == '0) begin
                            w_count_nxt = limit;
                            w_tc_nxt    = 1'b1;
                        end else begin
                            w_count_nxt = r_count - CNT_ONE;
                        end
                    end
                end
                MODE_ONESHOT: begin
                    if (w_up ? (r_count >= limit) : (r_count == '0)) begin
                        w_tc_nxt    = 1'b1;
                        w_state_nxt = ST_DONE;
                    end else if (w_up) begin
                        w_count_nxt = r_count + CNT_ONE;
                    end else begin
                        w_count_nxt = r_count - CNT_ONE;
                    end
                end
                default: begin
                    w_count_nxt = r_count;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_tc    <= 1'b0;
            r_done  <= 1'b0;
            r_state <= ST_RUN;
        end else begin
            r_count <= w_count_nxt;
            r_tc    <= w_tc_nxt;
            r_done  <= (w_state_nxt == ST_DONE);
            r_state <= w_state_nxt;
        end
    end

    assign count   = r_count;
    assign tc      = r_tc;
    assign done    = r_done;
    assign running = w_advance;

`ifdef PROG_COUNTER_CAPTURE_EN
    logic [WIDTH-1:0] r_cap_value;
    logic             r_cap_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cap_value <= '0;
            r_cap_valid <= 1'b0;
        end else begin
            r_cap_valid <= capture;
            if (capture) begin
                r_cap_value <= r_count;
            end
        end
    end

    assign cap_value = r_cap_value;
    assign cap_valid = r_cap_valid;
`endif

endmodule

// File: tb/tb_prog_counter.sv
// tb/tb_prog_counter.sv - table-driven, scoreboarded bench for prog_counter (WIDTH=8, PRE_W=4)
`timescale 1ns/1ps
module tb_prog_counter;
    import prog_counter_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en = 1'b0;
    logic [1:0] mode = MODE_FREE;
    logic       dir = 1'b1;
    logic       clear = 1'b0;
    logic       load_valid = 1'b0;
    logic [7:0] load_value = 8'h00;
    logic [7:0] limit = 8'h00;
    logic [3:0] prescale = 4'h0;
    logic [7:0] count;
    logic       tc;
    logic       done;
    logic       running;
`ifdef PROG_COUNTER_CAPTURE_EN
    logic       capture = 1'b0;
    logic [7:0] cap_value;
    logic       cap_valid;
`endif

    prog_counter #(.WIDTH(8), .PRE_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .mode       (mode),
        .dir        (dir),
        .clear      (clear),
        .load_valid (load_valid),
        .load_value (load_value),
        .limit      (limit),
        .prescale   (prescale),
`ifdef PROG_COUNTER_CAPTURE_EN
        .capture    (capture),
        .cap_value  (cap_value),
        .cap_valid  (cap_valid),
`endif
        .count      (count),
        .tc         (tc),
        .done       (done),
        .running    (running)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [1:0] mode;
        logic       dir;
        logic       clr;
        logic       ld;
        logic [7:0] ldv;
        logic [7:0] lim;
        logic [3:0] pre;
        logic [7:0] ec;
        logic       etc;
        logic       edone;
    } vec_t;

    typedef struct {
        logic [7:0] c;
        logic       tc;
        logic       done;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic void add(input logic e, input logic [1:0] m, input logic d,
                                input logic c, input logic l, input logic [7:0] lv,
                                input logic [7:0] lm, input logic [3:0] p,
                                input logic [7:0] ec, input logic et, input logic ed);
        vec_t v;
        v.en = e; v.mode = m; v.dir = d; v.clr = c; v.ld = l; v.ldv = lv;
        v.lim = lm; v.pre = p; v.ec = ec; v.etc = et; v.edone = ed;
        vecs.push_back(v);
    endfunction

    function automatic void fill();
        // modulo count up to 9, then reverse at 0
        add(1'b1, MODE_MOD, 1'b1, 1'b1, 1'b0, 8'h00, 8'd9, 4'd0, 8'd0, 1'b0, 1'b0);
        for (int k = 1; k <= 10; k++)
            add(1'b1, MODE_MOD, 1'b1, 1'b0, 1'b0, 8'h00, 8'd9, 4'd0, 8'(k % 10), (k == 10), 1'b0);
        add(1'b1, MODE_MOD, 1'b0, 1'b0, 1'b0, 8'h00, 8'd9, 4'd0, 8'd9, 1'b1, 1'b0);
        add(1'b1, MODE_MOD, 1'b0, 1'b0, 1'b0, 8'h00, 8'd9, 4'd0, 8'd8, 1'b0, 1'b0);
        // ONESHOT down from 5, park in DONE, reload 3
        add(1'b1, MODE_ONESHOT, 1'b0, 1'b0, 1'b1, 8'd5, 8'd9, 4'd0, 8'd5, 1'b0, 1'b0);
        for (int k = 4; k >= 0; k--)
            add(1'b1, MODE_ONESHOT, 1'b0, 1'b0, 1'b0, 8'h00, 8'd9, 4'd0, 8'(k), 1'b0, 1'b0);
        add(1'b1, MODE_ONESHOT, 1'b0, 1'b0, 1'b0, 8'h00, 8'd9, 4'd0, 8'd0, 1'b1, 1'b1);
        for (int k = 0; k < 20; k++)
            add(1'b1, MODE_ONESHOT, 1'b0, 1'b0, 1'b0, 8'h00, 8'd9, 4'd0, 8'd0, 1'b0, 1'b1);
        add(1'b1, MODE_ONESHOT, 1'b0, 1'b0, 1'b1, 8'd3, 8'd9, 4'd0, 8'd3, 1'b0, 1'b0);
        for (int k = 2; k >= 0; k--)
            add(1'b1, MODE_ONESHOT, 1'b0, 1'b0, 1'b0, 8'h00, 8'd9, 4'd0, 8'(k), 1'b0, 1'b0);
        add(1'b1, MODE_ONESHOT, 1'b0, 1'b0, 1'b0, 8'h00, 8'd9, 4'd0, 8'd0, 1'b1, 1'b1);
        // leaving ONESHOT releases DONE without a step, then FREE down wraps
        add(1'b1, MODE_FREE, 1'b0, 1'b0, 1'b0, 8'h00, 8'd9, 4'd0, 8'd0, 1'b0, 1'b0);
        add(1'b1, MODE_FREE, 1'b0, 1'b0, 1'b0, 8'h00, 8'd9, 4'd0, 8'hFF, 1'b1, 1'b0);
        // strobe priority on tick cycles
        add(1'b1, MODE_FREE, 1'b1, 1'b0, 1'b1, 8'hFF, 8'd9, 4'd0, 8'hFF, 1'b0, 1'b0);
        add(1'b1, MODE_FREE, 1'b1, 1'b1, 1'b1, 8'h7F, 8'd9, 4'd0, 8'h00, 1'b0, 1'b0);
        add(1'b1, MODE_FREE, 1'b1, 1'b0, 1'b1, 8'hFF, 8'd9, 4'd0, 8'hFF, 1'b0, 1'b0);
        add(1'b1, MODE_FREE, 1'b1, 1'b0, 1'b1, 8'h7F, 8'd9, 4'd0, 8'h7F, 1'b0, 1'b0);
        add(1'b1, MODE_FREE, 1'b1, 1'b0, 1'b0, 8'h00, 8'd9, 4'd0, 8'h80, 1'b0, 1'b0);
        add(1'b1, MODE_HOLD, 1'b1, 1'b0, 1'b0, 8'h00, 8'd9, 4'd0, 8'h80, 1'b0, 1'b0);
        add(1'b1, MODE_HOLD, 1'b1, 1'b0, 1'b0, 8'h00, 8'd9, 4'd0, 8'h80, 1'b0, 1'b0);
        // modulo count up with limit 0: above-limit count wraps, then tc every tick
        for (int k = 0; k < 3; k++)
            add(1'b1, MODE_MOD, 1'b1, 1'b0, 1'b0, 8'h00, 8'd0, 4'd0, 8'd0, 1'b1, 1'b0);
    endfunction

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_exp(input logic [7:0] c, input logic t, input logic d);
        exp_t e;
        e.c = c; e.tc = t; e.done = d;
        exp_q.push_back(e);
    endtask

    task automatic check_out(input string nm);
        exp_t e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL %s: scoreboard empty", nm);
        end else begin
            e = exp_q.pop_front();
            if (count !== e.c || tc !== e.tc || done !== e.done) begin
                n_err++;
                $display("FAIL %s: count=%0h tc=%0b done=%0b expected count=%0h tc=%0b done=%0b",
                         nm, count, tc, done, e.c, e.tc, e.done);
            end
        end
    endtask

    task automatic drive(input vec_t v);
        en = v.en; mode = v.mode; dir = v.dir; clear = v.clr; load_valid = v.ld;
        load_value = v.ldv; limit = v.lim; prescale = v.pre;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int tc_n, tc_at, bad;
        logic [7:0] prev;
        fill();

        #1 rst_n = 1'b0;
        #2;
        push_exp(8'h00, 1'b0, 1'b0);
        check_out("reset_state");
        chk("reset_running", running, 0);

        @(negedge clk);
        rst_n = 1'b1; en = 1'b1; mode = MODE_FREE; dir = 1'b1; prescale = 4'd0;
        tc_n = 0; tc_at = -1;
        for (int i = 1; i <= 300; i++) begin
            cyc();
            if (tc === 1'b1) begin
                tc_n++;
                tc_at = i;
            end
        end
        push_exp(8'd44, 1'b0, 1'b0);
        check_out("free_up_300");
        chk("free_up_tc_pulses", tc_n, 1);
        chk("free_up_tc_cycle", tc_at, 256);
        chk("free_running", running, 1);

        prescale = 4'd3; clear = 1'b1;
        cyc();
        clear = 1'b0;
        push_exp(8'd0, 1'b0, 1'b0);
        check_out("pre3_clear");
        bad = 0; prev = count;
        for (int i = 1; i <= 40; i++) begin
            cyc();
            if ((count != prev) != (i % 4 == 0)) bad++;
            prev = count;
        end
        chk("pre3_step_spacing", bad, 0);
        push_exp(8'd10, 1'b0, 1'b0);
        check_out("pre3_40_cycles");
        en = 1'b0;
        for (int i = 0; i < 10; i++) cyc();
        push_exp(8'd10, 1'b0, 1'b0);
        check_out("en_low_freeze");
        chk("en_low_running", running, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            push_exp(vecs[i].ec, vecs[i].etc, vecs[i].edone);
            cyc();
            check_out($sformatf("vec%0d", i));
        end
        clear = 1'b0; load_valid = 1'b0;

        mode = MODE_ONESHOT; dir = 1'b1; limit = 8'h42; prescale = 4'd0; en = 1'b1;
        load_valid = 1'b1; load_value = 8'h41;
        cyc();
        load_valid = 1'b0;
        push_exp(8'h41, 1'b0, 1'b0);
        check_out("os_up_load");
        cyc();
        push_exp(8'h42, 1'b0, 1'b0);
        check_out("os_up_step");
        cyc();
        push_exp(8'h42, 1'b1, 1'b1);
        check_out("os_up_terminal");
        #2 rst_n = 1'b0;
        #1;
        push_exp(8'h00, 1'b0, 1'b0);
        check_out("async_reset_midcycle");
        @(negedge clk);
        rst_n = 1'b1;

`ifdef PROG_COUNTER_CAPTURE_EN
        chk("cap_reset_value", cap_value, 0);
        chk("cap_reset_valid", cap_valid, 0);
        mode = MODE_FREE; dir = 1'b1; load_valid = 1'b1; load_value = 8'h20;
        cyc();
        load_valid = 1'b0;
        cyc();
        push_exp(8'h21, 1'b0, 1'b0);
        check_out("cap_pre_count");
        capture = 1'b1;
        cyc();
        capture = 1'b0;
        chk("cap_value", cap_value, 32'h21);
        chk("cap_valid_pulse", cap_valid, 1);
        chk("cap_count_unaffected", count, 32'h22);
        cyc();
        chk("cap_valid_drop", cap_valid, 0);
        chk("cap_value_hold", cap_value, 32'h21);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/prog_counter.md
Name: prog_counter

Overview:
- Parametrised, prescaled, multi-mode counter. Successor to the fixed 8-bit free-running counter on uo_out.
- Adds width and prescaler parameters, up/down counting, modulo and one-shot modes, synchronous load/clear, and a terminal-count pulse.
- Sits behind the tt_um top level; count drives uo_out; control comes from ui_in/uio_in.

Parameters:
WIDTH, 8, counter width in bits (>=2)
PRE_W, 4, prescaler compare width; tick period = prescale+1 enabled cycles

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
en  in  1  global count enable; when 0, prescaler and counter freeze
mode  in  2  00 FREE, 01 MOD, 10 ONESHOT, 11 HOLD
dir  in  1  1 = up, 0 = down
clear  in  1  synchronous clear strobe
load_valid  in  1  synchronous load strobe
load_value  in  WIDTH  value loaded on load_valid
limit  in  WIDTH  wrap/terminal value for MOD and ONESHOT
prescale  in  PRE_W  prescaler compare value
count  out  WIDTH  registered counter value
tc  out  1  registered one-cycle terminal-count pulse
done  out  1  registered; high while in DONE state
running  out  1  combinational: state==RUN && en && mode!=HOLD

Behaviour:
- Reset (rst_n low, async): count=0, pre_cnt=0, tc=0, done=0, state=RUN. Takes effect immediately, no clock edge needed.
- Prescaler: pre_cnt advances only when en=1 and mode!=HOLD and state==RUN.
  - tick=1 when pre_cnt==prescale; pre_cnt then returns to 0.
  - prescale=0 gives a tick every enabled cycle.
  - A prescale change below the current pre_cnt wraps pre_cnt through 2^PRE_W; no special handling.
- Priority per cycle: clear > load_valid > tick.
  - clear: count=0, pre_cnt=0, state=RUN, done=0.
  - load_valid: count=load_value, pre_cnt=0, state=RUN, done=0.
  - A tick in the same cycle as clear or load is discarded.
- tc defaults to 0 every cycle. It is 1 for exactly the cycle after a wrap/terminal event.
- On tick, decisions use the count value before stepping:
  - FREE up: count+1 mod 2^WIDTH; tc on 2^WIDTH-1 -> 0.
  - FREE down: count-1 mod 2^WIDTH; tc on 0 -> 2^WIDTH-1.
  - MOD up: if count>=limit, count=0 and tc; else count+1. A count above limit therefore wraps to 0 on the next tick.
  - MOD down: if count==0, count=limit and tc; else count-1.
  - ONESHOT up: if count>=limit, tc, state=DONE, count holds; else count+1.
  - ONESHOT down: if count==0, tc, state=DONE, count holds; else count-1.
  - HOLD: no change; prescaler frozen.
- FSM, two states:
  - RUN -> DONE on the ONESHOT terminal tick.
  - DONE -> RUN on clear, on load_valid, or when mode!=ONESHOT (next cycle, count unchanged).
  - In DONE: count frozen, done=1, no ticks, no further tc.
- Changes to mode, dir, limit or prescale mid-count apply from the next tick. count is never reset implicitly.
- limit=0 in MOD up: count stays at 0 and tc pulses every tick.

Optional Feature:
- Macro PROG_COUNTER_CAPTURE_EN.
- Defined: adds ports capture (in 1), cap_value (out WIDTH), cap_valid (out 1).
  - capture=1 latches the pre-update count into cap_value.
  - cap_valid pulses one cycle afterwards.
  - Both reset to 0.
  - Capture has no effect on counting.
- Undefined: these ports and registers do not exist. Counter behaviour is identical either way.

Decomposition:
- Package prog_counter_pkg holds:
  - mode enum: MODE_FREE=2'b00, MODE_MOD=2'b01, MODE_ONESHOT=2'b10, MODE_HOLD=2'b11
  - state enum: ST_RUN, ST_DONE
  - constants DIR_UP=1, DIR_DOWN=0
- Sub-module prog_counter_prescaler (param PRE_W).
  - Inputs: clk, rst_n, advance, restart, prescale.
  - Output: tick.
  - Owns pre_cnt.

Test Plan (WIDTH=8, PRE_W=4):
1. Reset; en=1, FREE, up, prescale=0, 300 cycles -> count=44; tc high exactly once, the cycle after 255->0.
2. prescale=3, FREE up from 0, 40 cycles -> count=10; count changes only every 4th cycle. Then en=0 for 10 cycles -> count stays 10.
3. MOD up, limit=9 -> sequence 0..9,0,1; tc once per 10 ticks. Switch to dir=0 at count=0 -> next values 9,8 with tc on 0->9.
4. ONESHOT down, load 5 -> 5,4,3,2,1,0; next tick tc=1, done=1, count stays 0 for 20 cycles. Then load_valid with load_value=3 -> done=0, count 3,2,...
5. clear and load_valid (value 0x7F) asserted together on a tick cycle -> count=0, no tc. load alone on a tick -> count=load_value, tick ignored.
6. Async reset mid-count (count=0x42) between clock edges -> count=0, tc=0, done=0 immediately. With PROG_COUNTER_CAPTURE_EN: capture at count=0x21 -> cap_value=0x21, cap_valid one cycle.
